// File: rtl/dp_bsram_pkg.sv
// Shared types and helpers for the parametrised dual-port block SRAM.
package dp_bsram_pkg;

  // Read-data behaviour of a port on a cycle where it writes.
  typedef enum logic [1:0] {
    WM_NORMAL        = 2'd0,
    WM_WRITE_THROUGH = 2'd1,
    WM_READ_FIRST    = 2'd2
  } wmode_t;

  // Byte-granular merge: take the new byte where enabled, keep the old one elsewhere.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dp_bsram_port.sv
// One port of the dual-port SRAM: range check, write-mode read mux,
// error flag and the optional output register stage.
module dp_bsram_port
  import dp_bsram_pkg::*;
#(
  parameter int     A_SIZE  = 13,
  parameter int     DEPTH   = 6144,
  parameter int     W_SIZE  = 16,
  parameter int     OUT_REG = 0,
  parameter wmode_t WMODE   = WM_NORMAL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              oce,
  input  logic              wr,
  input  logic [A_SIZE-1:0] addr,
  input  logic [W_SIZE-1:0] old_word,
  input  logic [W_SIZE-1:0] new_word,
  output logic              in_range,
  output logic [W_SIZE-1:0] dout,
  output logic              err
);

  localparam logic [A_SIZE:0] DEPTH_V = (A_SIZE+1)'(DEPTH);

  logic [W_SIZE-1:0] data_q;
  logic              err_q;
  logic [W_SIZE-1:0] data_o;
  logic              err_o;

  assign in_range = {1'b0, addr} < DEPTH_V;

  // Data stage: choose what this access returns; holds whenever the port is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (ce) begin
      if (!in_range) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end else begin
        err_q <= 1'b0;
        if (!wr) begin
          data_q <= old_word;
        end else if (WMODE == WM_WRITE_THROUGH) begin
          data_q <= new_word;
        end else if (WMODE == WM_READ_FIRST) begin
          data_q <= old_word;
        end
      end
    end
  end

  // Output stage: copies the data stage when its enable is high, else holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_o <= '0;
      err_o  <= 1'b0;
    end else if (oce) begin
      data_o <= data_q;
      err_o  <= err_q;
    end
  end

  assign dout = (OUT_REG != 0) ? data_o : data_q;
  assign err  = (OUT_REG != 0) ? err_o  : err_q;

endmodule

// File: rtl/dp_bsram_gen.sv
// Parametrised true dual-port block SRAM with byte enables, per-port write
// modes, range checking and same-address collision arbitration (port A wins).
module dp_bsram_gen
  import dp_bsram_pkg::*;
#(
  parameter int     A_SIZE  = 13,
  parameter int     DEPTH   = 6144,
  parameter int     W_SIZE  = 16,
  parameter int     OUT_REG = 0,
  parameter wmode_t WMODE_A = WM_NORMAL,
  parameter wmode_t WMODE_B = WM_NORMAL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cea,
  input  logic                ceb,
  input  logic                ocea,
  input  logic                oceb,
  input  logic                wra,
  input  logic                wrb,
  input  logic [W_SIZE/8-1:0] bea,
  input  logic [W_SIZE/8-1:0] beb,
  input  logic [A_SIZE-1:0]   addra,
  input  logic [A_SIZE-1:0]   addrb,
  input  logic [W_SIZE-1:0]   dina,
  input  logic [W_SIZE-1:0]   dinb,
  output logic [W_SIZE-1:0]   douta,
  output logic [W_SIZE-1:0]   doutb,
  output logic                erra,
  output logic                errb,
  output logic                coll
);

  localparam int NB = W_SIZE / 8;

  logic [W_SIZE-1:0] mem [DEPTH];

  logic              in_range_a, in_range_b;
  logic              we_a, we_b, same_addr, coll_now;
  logic [NB-1:0]     wmask_a, wmask_b;
  logic [W_SIZE-1:0] old_a, old_b, new_a, new_b;
  logic              coll_q, coll_o;

  assign old_a     = mem[addra];
  assign old_b     = mem[addrb];
  assign same_addr = (addra == addrb);
  assign we_a      = reset & cea & wra & in_range_a;
  assign we_b      = reset & ceb & wrb & in_range_b;
  assign wmask_a   = {NB{we_a}} & bea;
  assign wmask_b   = {NB{we_b}} & beb;
  assign coll_now  = cea & ceb & in_range_a & in_range_b & same_addr & (wra | wrb);

  // Word each address will hold after this edge; B is applied first so A wins overlaps.
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      new_a[8*i +: 8] = byte_merge(byte_merge(old_a[8*i +: 8], dinb[8*i +: 8],
                                              same_addr & wmask_b[i]),
                                   dina[8*i +: 8], wmask_a[i]);
      new_b[8*i +: 8] = byte_merge(byte_merge(old_b[8*i +: 8], dinb[8*i +: 8], wmask_b[i]),
                                   dina[8*i +: 8], same_addr & wmask_a[i]);
    end
  end

  // Array write: byte-granular, B drops any byte A also writes at the same address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wmask_a[i]) begin
        mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
      if (wmask_b[i] && !(same_addr && wmask_a[i])) begin
        mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
      end
    end
  end

  // Collision flag rides along the port A data stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_q <= 1'b0;
    end else if (cea) begin
      coll_q <= coll_now;
    end
  end

  // Collision flag output stage, enabled together with port A's output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_o <= 1'b0;
    end else if (ocea) begin
      coll_o <= coll_q;
    end
  end

  assign coll = (OUT_REG != 0) ? coll_o : coll_q;

  dp_bsram_port #(
    .A_SIZE (A_SIZE),
    .DEPTH  (DEPTH),
    .W_SIZE (W_SIZE),
    .OUT_REG(OUT_REG),
    .WMODE  (WMODE_A)
  ) u_port_a (
    .clk     (clk),
    .reset   (reset),
    .ce      (cea),
    .oce     (ocea),
    .wr      (wra),
    .addr    (addra),
    .old_word(old_a),
    .new_word(new_a),
    .in_range(in_range_a),
    .dout    (douta),
    .err     (erra)
  );

  dp_bsram_port #(
    .A_SIZE (A_SIZE),
    .DEPTH  (DEPTH),
    .W_SIZE (W_SIZE),
    .OUT_REG(OUT_REG),
    .WMODE  (WMODE_B)
  ) u_port_b (
    .clk     (clk),
    .reset   (reset),
    .ce      (ceb),
    .oce     (oceb),
    .wr      (wrb),
    .addr    (addrb),
    .old_word(old_b),
    .new_word(new_b),
    .in_range(in_range_b),
    .dout    (doutb),
    .err     (errb)
  );

endmodule

// File: tb/tb_dp_bsram_gen.sv
// Testbench for dp_bsram_gen: three instances (different write modes, one with
// the output register) share stimulus and are checked against a word-level model.
module tb_dp_bsram_gen;
  import dp_bsram_pkg::*;

  localparam int A_SIZE = 13;
  localparam int DEPTH  = 6144;
  localparam int W_SIZE = 16;
  localparam int NI     = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cea, ceb, ocea, oceb, wra, wrb;
  logic [1:0]  bea, beb;
  logic [12:0] addra, addrb;
  logic [15:0] dina, dinb;
  logic [15:0] douta_w [NI];
  logic [15:0] doutb_w [NI];
  logic        erra_w  [NI];
  logic        errb_w  [NI];
  logic        coll_w  [NI];

  int checks = 0;
  int errors = 0;

  bit [12:0] pool [10] = '{13'h000, 13'h005, 13'h010, 13'h100, 13'h101, 13'h7FF,
                           13'd6142, 13'd6143, 13'd6144, 13'd8191};

  // Model state: array contents plus data-stage and output-stage expectations.
  bit [15:0] mm   [8192];
  bit [15:0] s1_d [NI][2];
  bit        s1_e [NI][2];
  bit        s1_c [NI];
  bit [15:0] s2_d [NI][2];
  bit        s2_e [NI][2];
  bit        s2_c [NI];

  always #5 clk = ~clk;

  dp_bsram_gen #(.A_SIZE(A_SIZE), .DEPTH(DEPTH), .W_SIZE(W_SIZE), .OUT_REG(0),
                 .WMODE_A(WM_NORMAL), .WMODE_B(WM_NORMAL)) u0 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
    .wra(wra), .wrb(wrb), .bea(bea), .beb(beb), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta_w[0]), .doutb(doutb_w[0]),
    .erra(erra_w[0]), .errb(errb_w[0]), .coll(coll_w[0]));

  dp_bsram_gen #(.A_SIZE(A_SIZE), .DEPTH(DEPTH), .W_SIZE(W_SIZE), .OUT_REG(0),
                 .WMODE_A(WM_READ_FIRST), .WMODE_B(WM_WRITE_THROUGH)) u1 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
    .wra(wra), .wrb(wrb), .bea(bea), .beb(beb), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta_w[1]), .doutb(doutb_w[1]),
    .erra(erra_w[1]), .errb(errb_w[1]), .coll(coll_w[1]));

  dp_bsram_gen #(.A_SIZE(A_SIZE), .DEPTH(DEPTH), .W_SIZE(W_SIZE), .OUT_REG(1),
                 .WMODE_A(WM_WRITE_THROUGH), .WMODE_B(WM_READ_FIRST)) u2 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
    .wra(wra), .wrb(wrb), .bea(bea), .beb(beb), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta_w[2]), .doutb(doutb_w[2]),
    .erra(erra_w[2]), .errb(errb_w[2]), .coll(coll_w[2]));

  function automatic wmode_t mode_of(int k, int p);
    case (k)
      1:       return (p == 0) ? WM_READ_FIRST : WM_WRITE_THROUGH;
      2:       return (p == 0) ? WM_WRITE_THROUGH : WM_READ_FIRST;
      default: return WM_NORMAL;
    endcase
  endfunction

  function automatic logic [15:0] exp_dout(int k, int p);
    return (k == 2) ? s2_d[k][p] : s1_d[k][p];
  endfunction

  function automatic logic exp_err(int k, int p);
    return (k == 2) ? s2_e[k][p] : s1_e[k][p];
  endfunction

  function automatic logic exp_coll(int k);
    return (k == 2) ? s2_c[k] : s1_c[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      s1_c[k] = 0;
      s2_c[k] = 0;
      for (int p = 0; p < 2; p++) begin
        s1_d[k][p] = 0; s1_e[k][p] = 0; s2_d[k][p] = 0; s2_e[k][p] = 0;
      end
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit [15:0] pre [2];
    bit [15:0] post [2];
    bit        v [2];
    bit        ce [2];
    bit        wr [2];
    bit [12:0] ad [2];
    bit        hit;
    wmode_t    m;
    if (!reset) return;
    ad[0] = addra; ad[1] = addrb;
    ce[0] = cea;   ce[1] = ceb;
    wr[0] = wra;   wr[1] = wrb;
    for (int p = 0; p < 2; p++) begin
      v[p]   = int'(ad[p]) < DEPTH;
      pre[p] = v[p] ? mm[ad[p]] : 16'h0;
    end
    hit = cea && ceb && v[0] && v[1] && (addra == addrb) && (wra || wrb);
    // B lands first so A overrides bytes both ports write
    if (ceb && wrb && v[1])
      for (int i = 0; i < 2; i++) if (beb[i]) mm[addrb][8*i +: 8] = dinb[8*i +: 8];
    if (cea && wra && v[0])
      for (int i = 0; i < 2; i++) if (bea[i]) mm[addra][8*i +: 8] = dina[8*i +: 8];
    for (int p = 0; p < 2; p++) post[p] = v[p] ? mm[ad[p]] : 16'h0;
    for (int k = 0; k < NI; k++) begin
      if (ocea) begin s2_d[k][0] = s1_d[k][0]; s2_e[k][0] = s1_e[k][0]; s2_c[k] = s1_c[k]; end
      if (oceb) begin s2_d[k][1] = s1_d[k][1]; s2_e[k][1] = s1_e[k][1]; end
      for (int p = 0; p < 2; p++) begin
        if (ce[p]) begin
          if (!v[p]) begin
            s1_d[k][p] = 0; s1_e[k][p] = 1;
          end else begin
            s1_e[k][p] = 0;
            m = mode_of(k, p);
            if (!wr[p]) s1_d[k][p] = pre[p];
            else if (m == WM_WRITE_THROUGH) s1_d[k][p] = post[p];
            else if (m == WM_READ_FIRST) s1_d[k][p] = pre[p];
          end
        end
      end
      if (cea) s1_c[k] = hit;
    end
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_a(input logic c, input logic w, input logic [1:0] b,
                       input logic [12:0] a, input logic [15:0] d);
    cea = c; wra = w; bea = b; addra = a; dina = d;
  endtask

  task automatic set_b(input logic c, input logic w, input logic [1:0] b,
                       input logic [12:0] a, input logic [15:0] d);
    ceb = c; wrb = w; beb = b; addrb = a; dinb = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    clock_edge();
    clock_edge();
    for (int k = 0; k < NI; k++) begin
      checks++; if (douta_w[k] !== 16'h0) begin errors++; $display("[TB] FAIL reset_douta[%0d]: got %h expected 0000", k, douta_w[k]); end
      checks++; if (doutb_w[k] !== 16'h0) begin errors++; $display("[TB] FAIL reset_doutb[%0d]: got %h expected 0000", k, doutb_w[k]); end
      checks++; if ({erra_w[k], errb_w[k], coll_w[k]} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags[%0d]: got %b expected 000", k, {erra_w[k], errb_w[k], coll_w[k]}); end
    end
    reset = 1'b1;
  endtask

  task automatic init_pool();
    set_b(0, 0, 2'b00, 13'h0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      set_a(1, 1, 2'b11, pool[i], 16'($urandom));
      clock_edge();
    end
    set_a(0, 0, 2'b00, 13'h0, 16'h0);
    clock_edge();
  endtask

  task automatic test_reset_midread();
    set_a(1, 1, 2'b11, 13'h010, 16'hBEEF);
    clock_edge();
    set_a(1, 0, 2'b00, 13'h010, 16'h0);
    clock_edge();
    checks++; if (douta_w[0] !== 16'hBEEF) begin errors++; $display("[TB] FAIL pre_reset_read: got %h expected beef", douta_w[0]); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      checks++; if ({douta_w[k], doutb_w[k]} !== 32'h0) begin errors++; $display("[TB] FAIL midread_reset_dout[%0d]: got %h/%h expected 0", k, douta_w[k], doutb_w[k]); end
      checks++; if ({erra_w[k], errb_w[k], coll_w[k]} !== 3'b000) begin errors++; $display("[TB] FAIL midread_reset_flags[%0d]: got %b expected 000", k, {erra_w[k], errb_w[k], coll_w[k]}); end
    end
    @(negedge clk);
    set_a(1, 1, 2'b11, 13'h010, 16'h0000);
    clock_edge();
    checks++; if (douta_w[0] !== 16'h0) begin errors++; $display("[TB] FAIL held_in_reset: got %h expected 0000", douta_w[0]); end
    reset = 1'b1;
    set_a(1, 0, 2'b00, 13'h010, 16'h0);
    clock_edge();
    checks++; if (douta_w[0] !== 16'hBEEF) begin errors++; $display("[TB] FAIL post_reset_read: got %h expected beef", douta_w[0]); end
    checks++; if (douta_w[2] !== 16'h0) begin errors++; $display("[TB] FAIL post_reset_oreg_latency: got %h expected 0000", douta_w[2]); end
    clock_edge();
    checks++; if (douta_w[2] !== 16'hBEEF) begin errors++; $display("[TB] FAIL post_reset_oreg_read: got %h expected beef", douta_w[2]); end
  endtask

  task automatic test_byte_enable();
    set_b(0, 0, 2'b00, 13'h0, 16'h0);
    set_a(1, 1, 2'b11, 13'h005, 16'hFFFF);
    clock_edge();
    set_a(1, 1, 2'b01, 13'h005, 16'h1234);
    clock_edge();
    checks++; if (douta_w[1] !== 16'hFFFF) begin errors++; $display("[TB] FAIL be_read_first: got %h expected ffff", douta_w[1]); end
    set_a(1, 0, 2'b00, 13'h005, 16'h0);
    clock_edge();
    checks++; if (douta_w[0] !== 16'hFF34) begin errors++; $display("[TB] FAIL be_merge: got %h expected ff34", douta_w[0]); end
  endtask

  task automatic test_modes();
    set_a(1, 1, 2'b11, 13'h100, 16'hAAAA);
    clock_edge();
    set_a(1, 0, 2'b00, 13'h005, 16'h0);
    clock_edge();
    set_a(1, 1, 2'b11, 13'h100, 16'h5555);
    clock_edge();
    checks++; if (douta_w[0] !== 16'hFF34) begin errors++; $display("[TB] FAIL mode_normal: got %h expected ff34", douta_w[0]); end
    checks++; if (douta_w[1] !== 16'hAAAA) begin errors++; $display("[TB] FAIL mode_read_first: got %h expected aaaa", douta_w[1]); end
    set_a(0, 0, 2'b00, 13'h0, 16'h0);
    clock_edge();
    checks++; if (douta_w[2] !== 16'h5555) begin errors++; $display("[TB] FAIL mode_write_through: got %h expected 5555", douta_w[2]); end
    set_b(1, 0, 2'b00, 13'h005, 16'h0);
    clock_edge();
    set_b(1, 1, 2'b11, 13'h7FF, 16'hABCD);
    clock_edge();
    checks++; if (doutb_w[0] !== 16'hFF34) begin errors++; $display("[TB] FAIL mode_b_normal: got %h expected ff34", doutb_w[0]); end
    checks++; if (doutb_w[1] !== 16'hABCD) begin errors++; $display("[TB] FAIL mode_b_write_through: got %h expected abcd", doutb_w[1]); end
    set_b(0, 0, 2'b00, 13'h0, 16'h0);
  endtask

  task automatic test_range();
    set_a(1, 0, 2'b00, 13'd6144, 16'h0);
    clock_edge();
    checks++; if ({erra_w[0], douta_w[0]} !== {1'b1, 16'h0}) begin errors++; $display("[TB] FAIL range_read: got err=%b dout=%h expected err=1 dout=0000", erra_w[0], douta_w[0]); end
    set_a(0, 0, 2'b00, 13'h0, 16'h0);
    clock_edge();
    checks++; if (erra_w[0] !== 1'b1) begin errors++; $display("[TB] FAIL range_hold: got %b expected 1", erra_w[0]); end
    set_a(1, 1, 2'b11, 13'd6144, 16'hFFFF);
    clock_edge();
    checks++; if ({erra_w[0], douta_w[0]} !== {1'b1, 16'h0}) begin errors++; $display("[TB] FAIL range_write: got err=%b dout=%h expected err=1 dout=0000", erra_w[0], douta_w[0]); end
    set_a(1, 1, 2'b11, 13'd6143, 16'h4242);
    clock_edge();
    checks++; if (erra_w[0] !== 1'b0) begin errors++; $display("[TB] FAIL range_last_clear: got %b expected 0", erra_w[0]); end
    set_a(1, 0, 2'b00, 13'd6143, 16'h0);
    set_b(1, 0, 2'b00, 13'd8191, 16'h0);
    clock_edge();
    checks++; if (douta_w[0] !== 16'h4242) begin errors++; $display("[TB] FAIL range_last_word: got %h expected 4242", douta_w[0]); end
    checks++; if ({errb_w[0], doutb_w[0]} !== {1'b1, 16'h0}) begin errors++; $display("[TB] FAIL range_b: got err=%b dout=%h expected err=1 dout=0000", errb_w[0], doutb_w[0]); end
    set_b(0, 0, 2'b00, 13'h0, 16'h0);
  endtask

  task automatic test_collision();
    set_a(1, 1, 2'b11, 13'h100, 16'h1111);
    set_b(1, 1, 2'b10, 13'h100, 16'h2222);
    clock_edge();
    checks++; if (coll_w[0] !== 1'b1) begin errors++; $display("[TB] FAIL coll_ww_flag: got %b expected 1", coll_w[0]); end
    set_a(1, 0, 2'b00, 13'h100, 16'h0);
    set_b(1, 0, 2'b00, 13'h100, 16'h0);
    clock_edge();
    checks++; if ({douta_w[0], coll_w[0]} !== {16'h1111, 1'b0}) begin errors++; $display("[TB] FAIL coll_ww_word: got %h coll=%b expected 1111 coll=0", douta_w[0], coll_w[0]); end
    set_a(1, 1, 2'b11, 13'h100, 16'h3333);
    clock_edge();
    checks++; if ({doutb_w[0], coll_w[0]} !== {16'h1111, 1'b1}) begin errors++; $display("[TB] FAIL coll_wr: got %h coll=%b expected 1111 coll=1", doutb_w[0], coll_w[0]); end
    set_a(1, 1, 2'b01, 13'h100, 16'h00AA);
    set_b(1, 1, 2'b10, 13'h100, 16'hBB00);
    clock_edge();
    set_a(1, 0, 2'b00, 13'h100, 16'h0);
    set_b(0, 0, 2'b00, 13'h0, 16'h0);
    clock_edge();
    checks++; if (douta_w[0] !== 16'hBBAA) begin errors++; $display("[TB] FAIL coll_split_bytes: got %h expected bbaa", douta_w[0]); end
  endtask

  task automatic test_out_reg();
    set_a(1, 1, 2'b11, 13'h101, 16'hC0DE);
    ocea = 1'b1;
    clock_edge();
    set_a(1, 0, 2'b00, 13'h005, 16'h0);
    clock_edge();
    set_a(0, 0, 2'b00, 13'h0, 16'h0);
    clock_edge();
    set_a(1, 0, 2'b00, 13'h101, 16'h0);
    clock_edge();
    checks++; if (douta_w[2] !== 16'hFF34) begin errors++; $display("[TB] FAIL oreg_latency: got %h expected ff34", douta_w[2]); end
    set_a(0, 0, 2'b00, 13'h0, 16'h0);
    ocea = 1'b0;
    clock_edge();
    checks++; if (douta_w[2] !== 16'hFF34) begin errors++; $display("[TB] FAIL oreg_hold: got %h expected ff34", douta_w[2]); end
    ocea = 1'b1;
    clock_edge();
    checks++; if (douta_w[2] !== 16'hC0DE) begin errors++; $display("[TB] FAIL oreg_load: got %h expected c0de", douta_w[2]); end
  endtask

  task automatic test_back_to_back();
    bit [15:0] d [6];
    for (int i = 0; i < 6; i++) begin
      d[i] = 16'($urandom);
      set_a(1, 1, 2'b11, pool[i], d[i]);
      if (i > 0) set_b(1, 0, 2'b00, pool[i-1], 16'h0);
      clock_edge();
      if (i > 0) begin
        checks++; if (doutb_w[0] !== d[i-1]) begin errors++; $display("[TB] FAIL b2b_read[%0d]: got %h expected %h", i, doutb_w[0], d[i-1]); end
      end
    end
    set_a(0, 0, 2'b00, 13'h0, 16'h0);
    set_b(0, 0, 2'b00, 13'h0, 16'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_a($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), pool[$urandom_range(0, 9)], 16'($urandom));
      set_b($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), pool[$urandom_range(0, 9)], 16'($urandom));
      if ($urandom_range(0, 3) == 0) addrb = addra;
      ocea = $urandom_range(0, 3) != 0;
      oceb = $urandom_range(0, 3) != 0;
      clock_edge();
      for (int k = 0; k < NI; k++) begin
        checks++; if (douta_w[k] !== exp_dout(k, 0)) begin errors++; $display("[TB] FAIL rand_douta[%0d] n=%0d: got %h expected %h", k, n, douta_w[k], exp_dout(k, 0)); end
        checks++; if (doutb_w[k] !== exp_dout(k, 1)) begin errors++; $display("[TB] FAIL rand_doutb[%0d] n=%0d: got %h expected %h", k, n, doutb_w[k], exp_dout(k, 1)); end
        checks++; if (erra_w[k] !== exp_err(k, 0)) begin errors++; $display("[TB] FAIL rand_erra[%0d] n=%0d: got %b expected %b", k, n, erra_w[k], exp_err(k, 0)); end
        checks++; if (errb_w[k] !== exp_err(k, 1)) begin errors++; $display("[TB] FAIL rand_errb[%0d] n=%0d: got %b expected %b", k, n, errb_w[k], exp_err(k, 1)); end
        checks++; if (coll_w[k] !== exp_coll(k)) begin errors++; $display("[TB] FAIL rand_coll[%0d] n=%0d: got %b expected %b", k, n, coll_w[k], exp_coll(k)); end
      end
    end
    ocea = 1'b1;
    oceb = 1'b1;
  endtask

  initial begin
    ocea = 1'b1;
    oceb = 1'b1;
    set_a(0, 0, 2'b00, 13'h0, 16'h0);
    set_b(0, 0, 2'b00, 13'h0, 16'h0);
    test_reset();
    init_pool();
    test_reset_midread();
    test_byte_enable();
    test_modes();
    test_range();
    test_collision();
    test_out_reg();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
